// File: rtl/uart_rx18.sv
// uart_rx18: UART frame receiver (start, DATA_BITS data LSB first, stop) with a valid/ack output.
// Build option: define UART_RX_MAJORITY_EN for a 2-of-3 majority vote on every bit decision.

module uart_rx18 #(
  parameter int CLKS_PER_BIT = 576,
  parameter int DATA_BITS    = 18
) (
  input  logic                 sys_clk,
  input  logic                 sys_reset,
  input  logic                 uart_rxd,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_clk_cnt;
  logic [CNT_W-1:0]       w_clk_cnt_next;
  logic [IDX_W-1:0]       r_bit_idx;
  logic [IDX_W-1:0]       w_bit_idx_next;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift_next;
  logic [DATA_BITS-1:0]   r_out_data;
  logic [DATA_BITS-1:0]   w_out_data_next;
  logic                   r_out_valid;
  logic                   w_out_valid_next;
  logic                   r_rx_busy;
  logic                   r_frame_err;
  logic                   w_frame_err_next;
  logic                   r_overrun;
  logic                   w_overrun_next;

  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_rxd_d;
  logic                   w_fall;
  logic                   w_bit;

  // Two-flop synchroniser plus one delay flop for falling-edge detection; all idle high.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxd_d <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop take the old value of the
      // previous one, which is what builds a shift chain rather than a wire.
      r_sync1 <= uart_rxd;
      r_sync2 <= r_sync1;
      r_rxd_d <= r_sync2;
    end
  end

  assign w_fall = r_rxd_d & ~r_sync2;

`ifdef UART_RX_MAJORITY_EN
  logic [3:0] r_hist;

  // r_hist[1] is rxd_s two cycles ago, r_hist[3] four cycles ago.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_hist <= '1;
    end else begin
      r_hist <= {r_hist[2:0], r_sync2};
    end
  end

  assign w_bit = (r_sync2 & r_hist[1]) | (r_sync2 & r_hist[3]) | (r_hist[1] & r_hist[3]);
`else
  assign w_bit = r_sync2;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_state_next     = r_state;
    w_clk_cnt_next   = r_clk_cnt;
    w_bit_idx_next   = r_bit_idx;
    w_shift_next     = r_shift;
    w_out_data_next  = r_out_data;
    w_out_valid_next = r_out_valid;
    w_frame_err_next = 1'b0;
    w_overrun_next   = 1'b0;

    if (r_out_valid && rd_ack) begin
      w_out_valid_next = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_next   = S_START;
          w_clk_cnt_next = '0;
        end
      end

      S_START: begin
        if (r_clk_cnt == HALF_LAST) begin
          w_clk_cnt_next = '0;
          if (!w_bit) begin
            w_state_next   = S_DATA;
            w_bit_idx_next = '0;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_shift_next[r_bit_idx] = w_bit;
          w_clk_cnt_next          = '0;
          w_bit_idx_next          = r_bit_idx + IDX_W'(1);
          if (r_bit_idx == IDX_LAST) begin
            w_state_next = S_STOP;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (r_clk_cnt == BIT_LAST) begin
          w_state_next   = S_IDLE;
          w_clk_cnt_next = '0;
          if (w_bit) begin
            // A load beats a coincident ack; overrun only if the old frame was never taken.
            w_out_data_next  = r_shift;
            w_out_valid_next = 1'b1;
            w_overrun_next   = r_out_valid & ~rd_ack;
          end else begin
            w_frame_err_next = 1'b1;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      // NOTE: the assembly register is reset too, so an aborted frame leaves no
      // stale bits behind and post-reset behaviour is fully deterministic.
      r_shift     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_rx_busy   <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_clk_cnt   <= w_clk_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shift     <= w_shift_next;
      r_out_data  <= w_out_data_next;
      r_out_valid <= w_out_valid_next;
      r_rx_busy   <= (w_state_next != S_IDLE);
      r_frame_err <= w_frame_err_next;
      r_overrun   <= w_overrun_next;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign rx_busy   = r_rx_busy;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: doc/uart_rx18.md
Name: uart_rx18

Overview:
- Receive-side counterpart of the team's 18-channel UART transmitter.
- Deserialises 20-bit frames from a single serial line: start bit (0), 18 data bits LSB first, stop bit (1).
- Presents the 18 channel bits in parallel with a valid/ack handshake.
- Sits at the PC/FPGA link, or on a second board that consumes the neuron-state stream.

Parameters:
- CLKS_PER_BIT, 576, sys_clk cycles per bit (19200 baud at 11.0592 MHz). Must be even and >= 8.
- DATA_BITS, 18, data bits per frame.

Ports:
- sys_clk  in  1  system clock
- sys_reset  in  1  asynchronous, active-high reset
- uart_rxd  in  1  serial line, idle high, asynchronous to sys_clk
- rd_ack  in  1  consumer acknowledge; clears out_valid
- out_data  out  DATA_BITS  last good frame; bit 0 = first data bit received (in1)
- out_valid  out  1  level; high while out_data holds an unacknowledged frame
- rx_busy  out  1  high in any state other than IDLE
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- overrun  out  1  one-cycle pulse: good frame completed while out_valid was already high

Behaviour:
- Reset (async, sys_reset=1): state=IDLE, all counters 0, out_data=0, out_valid=0, rx_busy=0, frame_err=0, overrun=0, both synchroniser flops=1, edge-detect flop=1.
- Input path: uart_rxd passes through a 2-flop synchroniser to give rxd_s. A third flop holds rxd_d, the previous value of rxd_s.
- Counter widths: clk_cnt is clog2(CLKS_PER_BIT) bits; bit_idx is clog2(DATA_BITS) bits. HALF = CLKS_PER_BIT/2.
- IDLE:
  - Start detected when rxd_d=1 and rxd_s=0: go to START, clk_cnt=0.
  - A line held low (break) never retriggers. A 1 must be seen before the next falling edge.
- START:
  - clk_cnt increments each cycle.
  - At clk_cnt==HALF-1, sample rxd_s (mid start bit).
  - Sample 0: go to DATA, clk_cnt=0, bit_idx=0.
  - Sample 1: glitch. Go to IDLE silently, no flags.
- DATA:
  - At clk_cnt==CLKS_PER_BIT-1: shift_reg[bit_idx] <= sample, clk_cnt=0, bit_idx++.
  - After bit_idx==DATA_BITS-1 is stored, go to STOP. Otherwise clk_cnt increments.
  - Each sample is taken one bit period after the previous one, so every sample falls mid-bit.
- STOP:
  - At clk_cnt==CLKS_PER_BIT-1, sample the stop bit and return to IDLE in the same edge. This is mid stop bit, so a back-to-back next frame is caught.
  - Sample 1 (good frame): out_data <= shift_reg, out_valid <= 1. If out_valid was already 1 and rd_ack=0 that cycle, pulse overrun and overwrite out_data.
  - Sample 0: pulse frame_err for one cycle. out_data and out_valid are unchanged.
- Handshake:
  - out_valid rises on the cycle after the stop-bit sample edge.
  - rd_ack=1 with out_valid=1 clears out_valid next cycle.
  - rd_ack while out_valid=0 is ignored.
  - rd_ack coinciding with a good-frame load: the load wins, out_valid=1, no overrun.
- Latency:
  - The first falling edge of uart_rxd becomes visible in rxd_s after 2 cycles.
  - out_valid asserts (HALF + (DATA_BITS+1)*CLKS_PER_BIT + ~3) cycles after the edge. This is about 11236 cycles at defaults.
- rx_busy = (state != IDLE), registered.
- A reset mid-frame aborts the frame immediately. The partial shift_reg is discarded and no flags are raised.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit decision (start, data, stop) is a 2-of-3 majority vote.
  - Samples are rxd_s at the nominal decision cycle and at 2 and 4 cycles before it.
  - Sampling is still done through a sample history window, so decision timing is unchanged.
  - A 1-cycle glitch on any single sample does not corrupt the bit.
- Not defined: single sample of rxd_s at the decision cycle, as described above.

Test Plan:
- Reset, line idle high for 2000 cycles -> out_valid=0, rx_busy=0, out_data=18'h00000, no pulses.
- Frame 18'h2A5A5 at 576 cycles/bit, rd_ack held 0 -> out_data=18'h2A5A5, out_valid=1 and held, frame_err=0, rx_busy returns to 0.
- Two back-to-back frames 18'h3FFFF then 18'h00001, no rd_ack -> overrun pulses exactly once, out_data=18'h00001, out_valid=1. Repeat with rd_ack pulsed between frames -> no overrun.
- Frame 18'h12345 with stop bit driven 0 -> frame_err one-cycle pulse, out_data keeps the prior value, out_valid unchanged.
- 100-cycle low glitch on an idle line -> START aborts at the half-bit check, back to IDLE, no out_valid, no frame_err. Then a valid frame 18'h0F0F0 is received correctly.
- sys_reset asserted at data bit 9 of a frame -> outputs return to reset values asynchronously. The next full frame 18'h3C3C3 is received correctly. With UART_RX_MAJORITY_EN, 1-cycle glitches injected at each mid-bit still yield 18'h3C3C3.
